// File: rtl/anubis_pkg.sv
// Shared constants and types for the Anubis key-schedule sequencer.
package anubis_pkg;

    localparam int KEY_W      = 128;
    localparam int DEF_ROUNDS = 12;
    localparam int RK_ADDR_W  = $clog2(DEF_ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ks_state_e;

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Key-schedule bus: start handshake, round-key read port and the
// omega / evolution datapath connections.
interface key_sched_ctrl_if
    import anubis_pkg::*;
#(
    parameter int AW = RK_ADDR_W
) ();

    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             done;
    logic             rk_valid;
    logic [AW-1:0]    rk_rd_addr;
    logic [KEY_W-1:0] rk_rd_data;
    logic [KEY_W-1:0] omega_key;
    logic [KEY_W-1:0] omega_ext;
    logic [KEY_W-1:0] evo_key;
    logic [AW-1:0]    evo_rnd;
    logic [KEY_W-1:0] evo_next;

    // Requester side: key source, round core and the external datapaths.
    modport master (
        output start, key_in, rk_rd_addr, omega_ext, evo_next,
        input  busy, done, rk_valid, rk_rd_data, omega_key, evo_key, evo_rnd
    );

    // Sequencer side.
    modport slave (
        input  start, key_in, rk_rd_addr, omega_ext, evo_next,
        output busy, done, rk_valid, rk_rd_data, omega_key, evo_key, evo_rnd
    );

endinterface

// File: rtl/key_sched_ctrl_rk_buffer.sv
// Round-key register file: one write port, one registered read port.
// Out-of-range reads return zero. Storage is not reset.
module rk_buffer
    import anubis_pkg::*;
#(
    parameter int DEPTH = DEF_ROUNDS + 1,
    parameter int AW    = RK_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [KEY_W-1:0] rd_data
);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [KEY_W-1:0] mem_d [DEPTH];
    logic [KEY_W-1:0] rd_data_q;
    logic [KEY_W-1:0] rd_data_d;

    // Next-state for storage and read register.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr <= AW'(DEPTH - 1))) begin
            mem_d[waddr] = wdata;
        end
        rd_data_d = '0;
        if (rd_addr <= AW'(DEPTH - 1)) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage array, no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// Anubis key-schedule sequencer. Steps omega extraction and key evolution
// once per round and stores ROUNDS+1 round keys in rk_buffer.
// Optional feature: KEY_SCHED_CACHE_EN -- skip the run when the requested
// key equals the key of the last completed, still-valid schedule.
module key_sched_ctrl
    import anubis_pkg::*;
#(
    parameter int ROUNDS    = DEF_ROUNDS,
    parameter int OMEGA_LAT = 1,
    parameter int EVO_LAT   = 1
) (
    input  logic            clk,
    input  logic            rst,
    key_sched_ctrl_if.slave bus
);

    localparam int AW     = $clog2(ROUNDS + 1);
    localparam int L      = (OMEGA_LAT > EVO_LAT) ? OMEGA_LAT : EVO_LAT;
    localparam int WCNT_W = (L > 0) ? $clog2(L + 1) : 1;

    ks_state_e         state_q, state_d;
    logic [KEY_W-1:0]  k_q, k_d;
    logic [AW-1:0]     r_q, r_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              rk_valid_q, rk_valid_d;
    logic              wr_en;
`ifdef KEY_SCHED_CACHE_EN
    logic [KEY_W-1:0]  cache_key_q, cache_key_d;
    logic              cache_hit;
`endif

`ifdef KEY_SCHED_CACHE_EN
    // rk_valid guards the cache: it is low during a run and after reset,
    // so recording the key at start time is enough.
    assign cache_hit = rk_valid_q && (bus.key_in == cache_key_q);
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        r_d        = r_q;
        wcnt_d     = wcnt_q;
        rk_valid_d = rk_valid_q;
        wr_en      = 1'b0;
`ifdef KEY_SCHED_CACHE_EN
        cache_key_d = cache_key_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef KEY_SCHED_CACHE_EN
                    if (cache_hit) begin
                        state_d = DONE;
                    end else begin
                        cache_key_d = bus.key_in;
                        k_d         = bus.key_in;
                        r_d         = '0;
                        wcnt_d      = '0;
                        rk_valid_d  = 1'b0;
                        state_d     = RUN;
                    end
`else
                    k_d        = bus.key_in;
                    r_d        = '0;
                    wcnt_d     = '0;
                    rk_valid_d = 1'b0;
                    state_d    = RUN;
`endif
                end
            end
            RUN: begin
                if (wcnt_q == WCNT_W'(L)) begin
                    wr_en = 1'b1;
                    k_d   = bus.evo_next;
                    if (r_q == AW'(ROUNDS)) begin
                        state_d = DONE;
                    end else begin
                        r_d    = r_q + AW'(1);
                        wcnt_d = '0;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            DONE: begin
                rk_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            r_q        <= '0;
            wcnt_q     <= '0;
            rk_valid_q <= 1'b0;
`ifdef KEY_SCHED_CACHE_EN
            cache_key_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            r_q        <= r_d;
            wcnt_q     <= wcnt_d;
            rk_valid_q <= rk_valid_d;
`ifdef KEY_SCHED_CACHE_EN
            cache_key_q <= cache_key_d;
`endif
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.rk_valid  = rk_valid_q;
    assign bus.omega_key = k_q;
    assign bus.evo_key   = k_q;
    assign bus.evo_rnd   = r_q + AW'(1);

    rk_buffer #(
        .DEPTH (ROUNDS + 1),
        .AW    (AW)
    ) u_rk_buffer (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .waddr   (r_q),
        .wdata   (bus.omega_ext),
        .rd_addr (bus.rk_rd_addr),
        .rd_data (bus.rk_rd_data)
    );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: default-latency instance plus an
// OMEGA_LAT=1 / EVO_LAT=3 instance, with omega/evolution behavioural models.
module tb_key_sched_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] sb [$];

    always #5 clk = ~clk;

    key_sched_ctrl_if #(.AW(4)) bus1 ();
    key_sched_ctrl_if #(.AW(4)) bus2 ();

    key_sched_ctrl #(.ROUNDS(12), .OMEGA_LAT(1), .EVO_LAT(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    key_sched_ctrl #(.ROUNDS(12), .OMEGA_LAT(1), .EVO_LAT(3)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    // Datapath models: omega = key delayed, evolution = key+1 delayed.
    logic [127:0] om1_p, ev1_p, om2_p;
    logic [127:0] ev2_p [3];
    always @(posedge clk) begin
        om1_p    <= bus1.omega_key;
        ev1_p    <= bus1.evo_key + 128'd1;
        om2_p    <= bus2.omega_key;
        ev2_p[0] <= bus2.evo_key + 128'd1;
        ev2_p[1] <= ev2_p[0];
        ev2_p[2] <= ev2_p[1];
    end
    assign bus1.omega_ext = om1_p;
    assign bus1.evo_next  = ev1_p;
    assign bus2.omega_ext = om2_p;
    assign bus2.evo_next  = ev2_p[2];

    // Raise start for one cycle on the selected instance.
    task automatic launch(input int sel, input logic [127:0] key);
        @(posedge clk); #1;
        if (sel == 1) begin bus1.start = 1'b1; bus1.key_in = key; end
        else          begin bus2.start = 1'b1; bus2.key_in = key; end
    endtask

    // Step cycles, reporting the first done cycle, done pulses and busy.
    task automatic wait_done(input int sel, input int limit, output int first,
                             output int pulses, output int busy_seen);
        first = -1; pulses = 0; busy_seen = 0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(posedge clk); #1;
            bus1.start = 1'b0;
            bus2.start = 1'b0;
            if (((sel == 1) ? bus1.busy : bus2.busy) === 1'b1) busy_seen = 1;
            if (((sel == 1) ? bus1.done : bus2.done) === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
            end
        end
    endtask

    task automatic push_sched(input logic [127:0] key);
        for (int r = 0; r <= 12; r++) sb.push_back(key + 128'(r));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b0; bus1.key_in = '0; bus1.rk_rd_addr = '0;
        bus2.start = 1'b0; bus2.key_in = '0; bus2.rk_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus1.busy); end
        checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus1.done); end
        checks++; if (bus1.rk_valid !== 1'b0) begin errors++; $display("FAIL rst_rk_valid got %b want 0", bus1.rk_valid); end
        checks++; if (bus1.rk_rd_data !== 128'd0) begin errors++; $display("FAIL rst_rd_data got %h want 0", bus1.rk_rd_data); end
        checks++; if (bus1.omega_key !== 128'd0 || bus1.evo_key !== 128'd0) begin errors++; $display("FAIL rst_key got %h/%h want 0", bus1.omega_key, bus1.evo_key); end
        checks++; if (bus1.evo_rnd !== 4'd1) begin errors++; $display("FAIL rst_evo_rnd got %0d want 1", bus1.evo_rnd); end
        // start together with rst: rst must win
        bus1.start = 1'b1; bus1.key_in = 128'h55;
        @(posedge clk); #1;
        rst = 1'b0; bus1.start = 1'b0;
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rst_vs_start busy got %b want 0", bus1.busy); end
    endtask

    task automatic test_basic_run();
        int first, pulses, busy_seen;
        launch(1, 128'h0);
        push_sched(128'h0);
        wait_done(1, 40, first, pulses, busy_seen);
        checks++; if (first != 27) begin errors++; $display("FAIL basic_latency got %0d want 27", first); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", pulses); end
        checks++; if (bus1.rk_valid !== 1'b1) begin errors++; $display("FAIL basic_rk_valid got %b want 1", bus1.rk_valid); end
        for (int a = 0; a <= 12; a++) begin
            logic [127:0] exp;
            bus1.rk_rd_addr = 4'(a);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL basic_buf[%0d] got %h want %h", a, bus1.rk_rd_data, exp); end
        end
    endtask

    task automatic test_read_port();
        logic [127:0] exp;
        sb.push_back(128'h7);
        sb.push_back(128'h0);
        bus1.rk_rd_addr = 4'd7;
        @(posedge clk); #1;
        bus1.rk_rd_addr = 4'd13;
        exp = sb.pop_front();
        checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL read_addr7 got %h want %h", bus1.rk_rd_data, exp); end
        @(posedge clk); #1;
        exp = sb.pop_front();
        checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL read_addr13 got %h want %h", bus1.rk_rd_data, exp); end
        bus1.rk_rd_addr = 4'd0;
    endtask

    task automatic test_unequal_lat();
        int first, pulses, busy_seen;
        launch(2, 128'h100);
        push_sched(128'h100);
        wait_done(2, 60, first, pulses, busy_seen);
        checks++; if (first != 53) begin errors++; $display("FAIL unequal_latency got %0d want 53", first); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL unequal_done_pulses got %0d want 1", pulses); end
        for (int a = 0; a <= 12; a++) begin
            logic [127:0] exp;
            bus2.rk_rd_addr = 4'(a);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++; if (bus2.rk_rd_data !== exp) begin errors++; $display("FAIL unequal_buf[%0d] got %h want %h", a, bus2.rk_rd_data, exp); end
        end
    endtask

    task automatic test_start_ignored();
        int first, pulses;
        launch(1, 128'h1000);
        push_sched(128'h1000);
        first = -1; pulses = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            bus1.start  = (cyc == 5 || cyc == 26);
            bus1.key_in = (cyc == 5 || cyc == 26) ? 128'hDEAD : 128'h1000;
            if (bus1.done === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
            end
        end
        bus1.start = 1'b0;
        checks++; if (first != 27) begin errors++; $display("FAIL ignored_latency got %0d want 27", first); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignored_done_pulses got %0d want 1", pulses); end
        for (int a = 0; a <= 12; a++) begin
            logic [127:0] exp;
            bus1.rk_rd_addr = 4'(a);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL ignored_buf[%0d] got %h want %h", a, bus1.rk_rd_data, exp); end
        end
    endtask

    task automatic test_repeat_key();
        int first, pulses, busy_seen;
`ifdef KEY_SCHED_CACHE_EN
        int exp_lat = 1;
        int exp_busy = 0;
`else
        int exp_lat = 27;
        int exp_busy = 1;
`endif
        launch(1, 128'h1000);
        push_sched(128'h1000);
        wait_done(1, 40, first, pulses, busy_seen);
        checks++; if (first != exp_lat) begin errors++; $display("FAIL repeat_latency got %0d want %0d", first, exp_lat); end
        checks++; if (busy_seen != exp_busy) begin errors++; $display("FAIL repeat_busy got %0d want %0d", busy_seen, exp_busy); end
        checks++; if (bus1.rk_valid !== 1'b1) begin errors++; $display("FAIL repeat_rk_valid got %b want 1", bus1.rk_valid); end
        for (int a = 0; a <= 12; a++) begin
            logic [127:0] exp;
            bus1.rk_rd_addr = 4'(a);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL repeat_buf[%0d] got %h want %h", a, bus1.rk_rd_data, exp); end
        end
        // a new key always runs the full schedule
        launch(1, 128'h2000);
        push_sched(128'h2000);
        wait_done(1, 40, first, pulses, busy_seen);
        checks++; if (first != 27) begin errors++; $display("FAIL newkey_latency got %0d want 27", first); end
        for (int a = 0; a <= 12; a++) begin
            logic [127:0] exp;
            bus1.rk_rd_addr = 4'(a);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL newkey_buf[%0d] got %h want %h", a, bus1.rk_rd_data, exp); end
        end
    endtask

    task automatic test_reset_midrun();
        int first, pulses, busy_seen;
        launch(1, 128'h3000);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            bus1.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus1.busy); end
        checks++; if (bus1.rk_valid !== 1'b0) begin errors++; $display("FAIL midrst_rk_valid got %b want 0", bus1.rk_valid); end
        wait_done(1, 30, first, pulses, busy_seen);
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_done_pulses got %0d want 0", pulses); end
        launch(1, 128'h4000);
        push_sched(128'h4000);
        wait_done(1, 40, first, pulses, busy_seen);
        checks++; if (first != 27) begin errors++; $display("FAIL midrst_rerun_latency got %0d want 27", first); end
        for (int a = 0; a <= 12; a++) begin
            logic [127:0] exp;
            bus1.rk_rd_addr = 4'(a);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++; if (bus1.rk_rd_data !== exp) begin errors++; $display("FAIL midrst_buf[%0d] got %h want %h", a, bus1.rk_rd_data, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_read_port();
        test_unequal_lat();
        test_start_ignored();
        test_repeat_key();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
